equation_gen: RTL and testbench
===============================

// Module: equation_gen
// PURPOSE
//  Produces random arithmetic equations for the on-screen quiz. It sits directly upstream of
//  equation_display: num1/num2/operator feed the display, and result goes to answer checking.
//  Every emitted equation has all operands and the result in 0..MAX_NUM (two decimal digits).
//  A free-running LFSR supplies candidates; an FSM draws and checks them, retries rejected ones,
//  and falls back to a fixed equation if too many are rejected.
// PARAMETERS
//  LFSR_SEED  16'hACE1  LFSR value loaded at reset; a seed of 0 is replaced by 16'hACE1
//  MAX_NUM    99        upper bound for operands and result (must be <= 127)
//  MAX_TRIES  8         candidates drawn per request before the fallback is used (>= 1)
//  OP_MASK    4'b1111   operator enable, bit i enables op code i (0 +, 1 -, 2 x, 3 /)
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous, active-high reset
//  new_eq    in   1   request a new equation; sampled only in IDLE
//  num1      out  7   left operand, held stable between commits
//  num2      out  7   right operand, held stable between commits
//  operator  out  3   0 add, 1 sub, 2 mul, 3 div (codes 4/5 never driven)
//  result    out  7   correct answer for the current equation
//  eq_done   out  1   one-cycle pulse on the cycle the outputs change
//  eq_valid  out  1   high from the first commit until reset
//  busy      out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset: num1=num2=operator=result=0; eq_done=eq_valid=0; state=IDLE; tries=0; lfsr=seed.
//  LFSR: 16-bit Galois, mask 16'hB400, shifts right every cycle in all states (gives timing entropy).
//  Candidate fields, taken from the LFSR in DRAW: op=lfsr[1:0], A=lfsr[8:2], B=lfsr[15:9], B4=B[3:0].
//  FSM:
//   - IDLE: new_eq=1 -> DRAW, tries=0. Otherwise stay.
//   - DRAW: register op/A/B/B4 -> CHECK.
//   - CHECK: evaluate the candidate.
//     - valid: load outputs, pulse eq_done, set eq_valid -> IDLE.
//     - invalid with tries < MAX_TRIES-1: tries++ -> DRAW.
//     - invalid otherwise: load num1=1, num2=1, op=0, result=2; pulse eq_done -> IDLE.
//  Validity rules (any rule failing, or OP_MASK[op]=0, makes the candidate invalid):
//   - ADD: A<=MAX, B<=MAX, A+B<=MAX (8-bit sum). Out: num1=A, num2=B, result=A+B.
//   - SUB: A<=MAX, B<=MAX. Out: num1=max(A,B), num2=min(A,B), result=difference (never negative).
//   - MUL: A<=MAX, A*B4<=MAX (11-bit product). Out: num1=A, num2=B4, result=A*B4.
//   - DIV: B4!=0, A*B4<=MAX. Out: num1=A*B4, num2=B4, result=A (division is always exact, no divider).
//  Latency: new_eq sampled at edge k gives eq_done after edge k+2*n, where n = draws used (1..MAX_TRIES).
//  new_eq while busy is ignored, not queued. A level-high new_eq restarts a request on every return to IDLE.
//  Outputs change only at commit edges, so the display never shows a partially updated equation.
//  rst mid-request: abort to IDLE, restore reset values, and emit no eq_done.
// TESTING
//  1. Reset, then idle 10 cycles -> all outputs 0, busy=0, eq_done never 1.
//  2. OP_MASK=4'b0000, MAX_TRIES=3, pulse new_eq -> eq_done exactly 6 cycles later; 1,+,1,2.
//  3. OP_MASK=4'b0001, 500 requests -> operator=0 every time, num1+num2==result<=99.
//  4. Default parameters, 2000 requests -> every commit obeys the rules, num1/num2/result<=99,
//     div num1==num2*result with num2!=0, and all four ops are seen.
//  5. new_eq pulsed while busy -> ignored; exactly one eq_done per accepted request.
//  6. rst asserted in CHECK -> next cycle outputs 0, eq_valid=0, busy=0, no eq_done.

Source files
------------

// File: rtl/equation_gen_if.sv
// Quiz equation bus: request strobe in, committed equation and status out.
// The generator takes the master side; the consumer/requester takes the slave side.
interface equation_gen_if;
    logic       new_eq;
    logic [6:0] num1;
    logic [6:0] num2;
    logic [2:0] operator;
    logic [6:0] result;
    logic       eq_done;
    logic       eq_valid;
    logic       busy;

    modport master (
        input  new_eq,
        output num1,
        output num2,
        output operator,
        output result,
        output eq_done,
        output eq_valid,
        output busy
    );

    modport slave (
        output new_eq,
        input  num1,
        input  num2,
        input  operator,
        input  result,
        input  eq_done,
        input  eq_valid,
        input  busy
    );
endinterface

// File: rtl/equation_gen.sv
// Random two-digit arithmetic equation generator: an LFSR feeds candidates to a
// draw/check FSM that retries rejects and falls back to 1+1=2 after MAX_TRIES draws.
module equation_gen #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned MAX_NUM   = 99,
    parameter int unsigned MAX_TRIES = 8,
    parameter logic [3:0]  OP_MASK   = 4'b1111
) (
    input logic            clk,
    input logic            rst,
    equation_gen_if.master bus
);

    localparam logic [15:0] SeedEff   = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [15:0] LfsrMask  = 16'hB400;
    localparam int unsigned TriesW    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TriesW-1:0] LastTry = TriesW'(MAX_TRIES - 1);
    localparam logic [10:0] MaxNum    = 11'(MAX_NUM);

    typedef enum logic [1:0] {StIdle, StDraw, StCheck} state_e;

    state_e            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [TriesW-1:0] tries_q, tries_d;
    logic [1:0]        cand_op_q, cand_op_d;
    logic [6:0]        cand_a_q, cand_a_d;
    logic [6:0]        cand_b_q, cand_b_d;
    logic [6:0]        num1_q, num1_d;
    logic [6:0]        num2_q, num2_d;
    logic [2:0]        operator_q, operator_d;
    logic [6:0]        result_q, result_d;
    logic              eq_done_q, eq_done_d;
    logic              eq_valid_q, eq_valid_d;

    // Candidate evaluation
    logic [3:0]  cand_b4;
    logic [7:0]  sum;
    logic [10:0] prod;
    logic        a_ok, b_ok, sum_ok, prod_ok;
    logic        cand_ok;
    logic [6:0]  cand_n1, cand_n2, cand_res;

    assign lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrMask : 16'h0000);

    assign cand_b4 = cand_b_q[3:0];
    assign sum     = {1'b0, cand_a_q} + {1'b0, cand_b_q};
    assign prod    = {4'b0000, cand_a_q} * {7'b0000000, cand_b4};
    assign a_ok    = {4'b0000, cand_a_q} <= MaxNum;
    assign b_ok    = {4'b0000, cand_b_q} <= MaxNum;
    assign sum_ok  = {3'b000, sum} <= MaxNum;
    assign prod_ok = prod <= MaxNum;

    always_comb begin
        cand_ok  = 1'b0;
        cand_n1  = '0;
        cand_n2  = '0;
        cand_res = '0;
        unique case (cand_op_q)
            2'd0: begin
                cand_ok  = a_ok && b_ok && sum_ok;
                cand_n1  = cand_a_q;
                cand_n2  = cand_b_q;
                cand_res = sum[6:0];
            end
            2'd1: begin
                cand_ok = a_ok && b_ok;
                if (cand_a_q >= cand_b_q) begin
                    cand_n1 = cand_a_q;
                    cand_n2 = cand_b_q;
                end else begin
                    cand_n1 = cand_b_q;
                    cand_n2 = cand_a_q;
                end
                cand_res = cand_n1 - cand_n2;
            end
            2'd2: begin
                cand_ok  = a_ok && prod_ok;
                cand_n1  = cand_a_q;
                cand_n2  = {3'b000, cand_b4};
                cand_res = prod[6:0];
            end
            2'd3: begin
                // Division is built backwards from a product so it is always exact.
                cand_ok  = (cand_b4 != 4'd0) && prod_ok;
                cand_n1  = prod[6:0];
                cand_n2  = {3'b000, cand_b4};
                cand_res = cand_a_q;
            end
            default: cand_ok = 1'b0;
        endcase
        if (!OP_MASK[cand_op_q]) begin
            cand_ok = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        tries_d    = tries_q;
        cand_op_d  = cand_op_q;
        cand_a_d   = cand_a_q;
        cand_b_d   = cand_b_q;
        num1_d     = num1_q;
        num2_d     = num2_q;
        operator_d = operator_q;
        result_d   = result_q;
        eq_done_d  = 1'b0;
        eq_valid_d = eq_valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.new_eq) begin
                    state_d = StDraw;
                    tries_d = '0;
                end
            end
            StDraw: begin
                cand_op_d = lfsr_q[1:0];
                cand_a_d  = lfsr_q[8:2];
                cand_b_d  = lfsr_q[15:9];
                state_d   = StCheck;
            end
            StCheck: begin
                if (cand_ok) begin
                    num1_d     = cand_n1;
                    num2_d     = cand_n2;
                    operator_d = {1'b0, cand_op_q};
                    result_d   = cand_res;
                    eq_done_d  = 1'b1;
                    eq_valid_d = 1'b1;
                    state_d    = StIdle;
                end else if (tries_q < LastTry) begin
                    tries_d = tries_q + 1'b1;
                    state_d = StDraw;
                end else begin
                    num1_d     = 7'd1;
                    num2_d     = 7'd1;
                    operator_d = 3'd0;
                    result_d   = 7'd2;
                    eq_done_d  = 1'b1;
                    eq_valid_d = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            lfsr_q     <= SeedEff;
            tries_q    <= '0;
            cand_op_q  <= '0;
            cand_a_q   <= '0;
            cand_b_q   <= '0;
            num1_q     <= '0;
            num2_q     <= '0;
            operator_q <= '0;
            result_q   <= '0;
            eq_done_q  <= 1'b0;
            eq_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            tries_q    <= tries_d;
            cand_op_q  <= cand_op_d;
            cand_a_q   <= cand_a_d;
            cand_b_q   <= cand_b_d;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            operator_q <= operator_d;
            result_q   <= result_d;
            eq_done_q  <= eq_done_d;
            eq_valid_q <= eq_valid_d;
        end
    end

    assign bus.num1     = num1_q;
    assign bus.num2     = num2_q;
    assign bus.operator = operator_q;
    assign bus.result   = result_q;
    assign bus.eq_done  = eq_done_q;
    assign bus.eq_valid = eq_valid_q;
    assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_equation_gen.sv
// Bench for equation_gen: three instances (default, all ops masked, add only) checked
// against a reference LFSR/validity model plus hand-computed directed equations.
module tb_equation_gen;

    localparam logic [15:0] Seed = 16'hACE1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    equation_gen_if bus [3] ();

    equation_gen #(.LFSR_SEED(Seed), .MAX_NUM(99), .MAX_TRIES(8), .OP_MASK(4'b1111)) dut0 (
        .clk(clk), .rst(rst), .bus(bus[0])
    );
    equation_gen #(.LFSR_SEED(Seed), .MAX_NUM(99), .MAX_TRIES(3), .OP_MASK(4'b0000)) dut1 (
        .clk(clk), .rst(rst), .bus(bus[1])
    );
    equation_gen #(.LFSR_SEED(Seed), .MAX_NUM(99), .MAX_TRIES(8), .OP_MASK(4'b0001)) dut2 (
        .clk(clk), .rst(rst), .bus(bus[2])
    );

    logic       req   [3];
    logic       done  [3];
    logic       valid [3];
    logic       busyv [3];
    logic [6:0] n1v   [3];
    logic [6:0] n2v   [3];
    logic [2:0] opv   [3];
    logic [6:0] resv  [3];

    for (genvar g = 0; g < 3; g++) begin : g_tap
        assign bus[g].new_eq = req[g];
        assign done[g]       = bus[g].eq_done;
        assign valid[g]      = bus[g].eq_valid;
        assign busyv[g]      = bus[g].busy;
        assign n1v[g]        = bus[g].num1;
        assign n2v[g]        = bus[g].num2;
        assign opv[g]        = bus[g].operator;
        assign resv[g]       = bus[g].result;
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] m_lfsr;
    int last_lat, last_n1, last_n2, last_op, last_res;
    int ops_seen [4];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic [15:0] step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [3:0] mask_of(input int idx);
        case (idx)
            0:       return 4'b1111;
            1:       return 4'b0000;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic int tries_of(input int idx);
        return (idx == 1) ? 3 : 8;
    endfunction

    function automatic bit evaluate(input logic [15:0] l, input logic [3:0] mask,
                                    output int n1, output int n2, output int op,
                                    output int res);
        int a, b, b4;
        op = int'(l[1:0]);
        a  = int'(l[8:2]);
        b  = int'(l[15:9]);
        b4 = b % 16;
        n1 = 0; n2 = 0; res = 0;
        if (!mask[op]) return 1'b0;
        case (op)
            0: if (a <= 99 && b <= 99 && a + b <= 99) begin
                n1 = a; n2 = b; res = a + b; return 1'b1;
            end
            1: if (a <= 99 && b <= 99) begin
                n1 = (a > b) ? a : b; n2 = (a > b) ? b : a; res = n1 - n2; return 1'b1;
            end
            2: if (a <= 99 && a * b4 <= 99) begin
                n1 = a; n2 = b4; res = a * b4; return 1'b1;
            end
            default: if (b4 != 0 && a * b4 <= 99) begin
                n1 = a * b4; n2 = b4; res = a; return 1'b1;
            end
        endcase
        return 1'b0;
    endfunction

    // m_lfsr is the generator LFSR value just after the most recent edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) m_lfsr = Seed;
        else     m_lfsr = step(m_lfsr);
    endtask

    task automatic predict(input int idx, output int n, output int n1, output int n2,
                           output int op, output int res);
        logic [15:0] l;
        l = m_lfsr;
        for (int t = 1; t <= tries_of(idx); t++) begin
            if (evaluate(l, mask_of(idx), n1, n2, op, res)) begin
                n = t;
                return;
            end
            l = step(step(l));
        end
        n = tries_of(idx); n1 = 1; n2 = 1; op = 0; res = 2;
    endtask

    // One request; 'extra' further new_eq pulses land while the FSM is busy.
    task automatic request(input int idx, input int extra);
        int n, e1, e2, eop, eres, t, pulses;
        req[idx] = 1'b1;
        tick();
        req[idx] = 1'b0;
        predict(idx, n, e1, e2, eop, eres);
        check("busy_after_req", int'(busyv[idx]), 1);
        t = 0;
        pulses = 0;
        for (int c = 1; c <= 2 * tries_of(idx) + 2; c++) begin
            if (c <= extra) req[idx] = 1'b1;
            tick();
            req[idx] = 1'b0;
            if (done[idx]) begin
                pulses++;
                if (t == 0) t = c;
            end
        end
        check("latency", t, 2 * n);
        check("done_pulses", pulses, 1);
        check("num1", int'(n1v[idx]), e1);
        check("num2", int'(n2v[idx]), e2);
        check("operator", int'(opv[idx]), eop);
        check("result", int'(resv[idx]), eres);
        check("eq_valid", int'(valid[idx]), 1);
        check("busy_idle", int'(busyv[idx]), 0);
        last_lat = t;
        last_n1  = int'(n1v[idx]);
        last_n2  = int'(n2v[idx]);
        last_op  = int'(opv[idx]);
        last_res = int'(resv[idx]);
    endtask

    task automatic check_reset_state(input int idx);
        check("rst_num1", int'(n1v[idx]), 0);
        check("rst_num2", int'(n2v[idx]), 0);
        check("rst_operator", int'(opv[idx]), 0);
        check("rst_result", int'(resv[idx]), 0);
        check("rst_eq_done", int'(done[idx]), 0);
        check("rst_eq_valid", int'(valid[idx]), 0);
        check("rst_busy", int'(busyv[idx]), 0);
    endtask

    initial begin
        int done_cnt;
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        for (int i = 0; i < 4; i++) ops_seen[i] = 0;
        m_lfsr = Seed;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset: nothing moves.
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int i = 0; i < 3; i++) if (done[i]) done_cnt++;
        end
        check("idle_done_count", done_cnt, 0);
        for (int i = 0; i < 3; i++) check_reset_state(i);

        // First request straight after reset: draw E270 (B=113) rejected, 389C gives 39+28.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        request(0, 0);
        check("first_lat", last_lat, 4);
        check("first_num1", last_n1, 39);
        check("first_num2", last_n2, 28);
        check("first_op", last_op, 0);
        check("first_res", last_res, 67);

        // All operators disabled: fallback 1+1=2 after 3 draws.
        for (int r = 0; r < 2; r++) begin
            request(1, 0);
            check("fb_lat", last_lat, 6);
            check("fb_num1", last_n1, 1);
            check("fb_num2", last_n2, 1);
            check("fb_op", last_op, 0);
            check("fb_res", last_res, 2);
        end

        // Add-only generator.
        for (int r = 0; r < 100; r++) begin
            repeat ($urandom_range(0, 3)) tick();
            request(2, 0);
            check("add_only_op", last_op, 0);
        end

        // Full generator, with busy-time new_eq pulses mixed in.
        for (int r = 0; r < 300; r++) begin
            repeat ($urandom_range(0, 3)) tick();
            request(0, int'($urandom_range(0, 2)));
            if (last_op >= 0 && last_op < 4) ops_seen[last_op]++;
        end
        for (int i = 0; i < 4; i++) check("op_seen", int'(ops_seen[i] > 0), 1);

        // Reset while in CHECK: outputs clear, no eq_done.
        req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        tick();
        check("in_check_busy", int'(busyv[0]), 1);
        rst = 1'b1;
        tick();
        check_reset_state(0);
        rst = 1'b0;
        tick();
        check("post_rst_done", int'(done[0]), 0);
        check("post_rst_busy", int'(busyv[0]), 0);
        request(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
